// File: rtl/conv_encoder_puncturer.sv
// rtl/conv_encoder_puncturer.sv - 802.11a K=7 convolutional encoder with rate 1/2, 2/3, 3/4 puncturing
// Accepts one scrambled bit per handshake and serialises the kept coded bits, A before B.
module conv_encoder_puncturer (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] Rate,
   input  logic       InValid,
   input  logic       InData,
   output logic       InReady,
   input  logic       OutReady,
   output logic       OutValid,
   output logic       OutData
);

   typedef enum logic [1:0] {READY, EMIT_A, EMIT_B} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [5:0] sr;
   logic [1:0] rate_q;
   logic [1:0] phase;
   logic [1:0] phase_last;
   logic       a_q;
   logic       b_q;
   logic       keepb_q;
   logic       accept;
   logic       enc_a;
   logic       enc_b;
   logic       keep_a;
   logic       keep_b;

   assign accept = (state == READY) && InValid && !Start;
   assign enc_a  = InData ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
   assign enc_b  = InData ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];

   // Rate 11 falls through to the rate 1/2 pattern.
   always_comb begin
      keep_a     = 1'b1;
      keep_b     = 1'b1;
      phase_last = 2'd0;
      case (rate_q)
         2'b01: begin
            phase_last = 2'd1;
            keep_b     = (phase != 2'd1);
         end
         2'b10: begin
            phase_last = 2'd2;
            keep_b     = (phase != 2'd1);
            keep_a     = (phase != 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sr      <= 6'd0;
         phase   <= 2'd0;
         rate_q  <= 2'b00;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         keepb_q <= 1'b0;
      end else if (Start) begin
         sr     <= 6'd0;
         phase  <= 2'd0;
         rate_q <= Rate;
      end else if (accept) begin
         a_q     <= enc_a;
         b_q     <= enc_b;
         keepb_q <= keep_b;
         sr      <= {sr[4:0], InData};
         phase   <= (phase == phase_last) ? 2'd0 : phase + 2'd1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= READY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (Start) begin
         state_nxt = READY;
      end else begin
         case (state)
            READY:   if (InValid)  state_nxt = keep_a ? EMIT_A : EMIT_B;
            EMIT_A:  if (OutReady) state_nxt = keepb_q ? EMIT_B : READY;
            EMIT_B:  if (OutReady) state_nxt = READY;
            default: state_nxt = READY;
         endcase
      end
   end

   // Start masks the pending bit so a discarded A/B can never be handed downstream.
   always_comb begin
      InReady  = (state == READY) && !Start;
      OutValid = 1'b0;
      OutData  = 1'b0;
      case (state)
         EMIT_A: begin
            OutValid = !Start;
            OutData  = a_q && !Start;
         end
         EMIT_B: begin
            OutValid = !Start;
            OutData  = b_q && !Start;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_conv_encoder_puncturer.sv
// tb/tb_conv_encoder_puncturer.sv - self-checking bench for conv_encoder_puncturer
// A generator-polynomial model fills the expected queue at each accept; a monitor records handed-over bits.
module tb_conv_encoder_puncturer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic [1:0] Rate = 2'b00;
   logic       InValid = 1'b0;
   logic       InData = 1'b0;
   logic       InReady;
   logic       OutReady = 1'b1;
   logic       OutValid;
   logic       OutData;

   int errors = 0;
   int checks = 0;
   int lost = 0;

   logic obs_q[$];
   logic exp_q[$];

   logic [5:0] m_h;
   logic [1:0] m_rate;
   logic [1:0] m_phase;

   conv_encoder_puncturer dut (
      .Clock(Clock),
      .Reset(Reset),
      .Start(Start),
      .Rate(Rate),
      .InValid(InValid),
      .InData(InData),
      .InReady(InReady),
      .OutReady(OutReady),
      .OutValid(OutValid),
      .OutData(OutData)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock)
      if (!Reset && OutValid && OutReady) obs_q.push_back(OutData);

   task automatic model_start(input logic [1:0] r);
      m_h     = 6'd0;
      m_phase = 2'd0;
      m_rate  = r;
      obs_q.delete();
      exp_q.delete();
   endtask

   // m_h[5] is delay 1, m_h[0] is delay 6; window bit 6 is the current bit.
   task automatic model_accept(input logic d);
      logic [6:0] w;
      logic       a, b, ka, kb;
      logic [1:0] last;
      w    = {d, m_h};
      a    = ^(w & 7'o133);
      b    = ^(w & 7'o171);
      ka   = 1'b1;
      kb   = 1'b1;
      last = 2'd0;
      if (m_rate == 2'b01) begin
         last = 2'd1;
         kb   = (m_phase != 2'd1);
      end else if (m_rate == 2'b10) begin
         last = 2'd2;
         kb   = (m_phase != 2'd1);
         ka   = (m_phase != 2'd2);
      end
      if (ka) exp_q.push_back(a);
      if (kb) exp_q.push_back(b);
      m_h     = w[6:1];
      m_phase = (m_phase == last) ? 2'd0 : m_phase + 2'd1;
   endtask

   task automatic do_start(input logic [1:0] r);
      Rate  = r;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      model_start(r);
   endtask

   task automatic send_bit(input logic d);
      int k;
      k       = 0;
      InValid = 1'b1;
      InData  = d;
      @(negedge Clock);
      while (!InReady && k < 200) begin
         @(negedge Clock);
         k++;
      end
      if (InReady) begin
         @(posedge Clock);
         model_accept(d);
      end else begin
         lost++;
      end
      #1;
      InValid = 1'b0;
      InData  = 1'b0;
   endtask

   task automatic collect(output int n_obs, output int n_exp,
                          output logic [127:0] vo, output logic [127:0] ve);
      int k;
      k = 0;
      while (obs_q.size() < exp_q.size() && k < 500) begin
         @(posedge Clock);
         k++;
      end
      repeat (4) @(posedge Clock);
      #1;
      n_obs = obs_q.size();
      n_exp = exp_q.size();
      vo = '0;
      ve = '0;
      while (obs_q.size() > 0) vo = {vo[126:0], obs_q.pop_front()};
      while (exp_q.size() > 0) ve = {ve[126:0], exp_q.pop_front()};
   endtask

   task automatic test_reset;
      @(negedge Clock);
      checks++;
      if (InReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_inready: got %b want 1", InReady);
      end
      checks++;
      if (OutValid !== 1'b0 || OutData !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%b want 0 0", OutValid, OutData);
      end
      @(posedge Clock);
      #1;
      Reset = 1'b0;
   endtask

   task automatic run_directed(input string name, input logic [1:0] r, input int nbits,
                               input int want_n, input logic [127:0] want_v);
      int n_obs, n_exp;
      logic [127:0] vo, ve;
      lost = 0;
      do_start(r);
      for (int i = 0; i < nbits; i++) send_bit(i == 0);
      collect(n_obs, n_exp, vo, ve);
      checks++;
      if (lost != 0 || n_obs != n_exp || vo !== ve) begin
         errors++;
         $display("FAIL %s_scoreboard: got n=%0d bits=%h want n=%0d bits=%h lost=%0d",
                  name, n_obs, vo, n_exp, ve, lost);
      end
      checks++;
      if (n_obs != want_n || vo !== want_v) begin
         errors++;
         $display("FAIL %s_vector: got n=%0d bits=%h want n=%0d bits=%h",
                  name, n_obs, vo, want_n, want_v);
      end
   endtask

   task automatic test_rate_half;
      run_directed("rate12", 2'b00, 7, 14, 128'b11011111001011);
   endtask

   task automatic test_rate_34;
      run_directed("rate34", 2'b10, 6, 8, 128'b11011100);
   endtask

   task automatic test_rate_23;
      run_directed("rate23", 2'b01, 4, 6, 128'b110111);
   endtask

   task automatic test_backpressure;
      int n_obs, n_exp;
      logic [127:0] vo, ve;
      lost = 0;
      do_start(2'b00);
      OutReady = 1'b0;
      send_bit(1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         checks++;
         if (OutValid !== 1'b1 || OutData !== 1'b1 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: got valid=%b data=%b inready=%b want 1 1 0",
                     i, OutValid, OutData, InReady);
         end
      end
      @(posedge Clock);
      #1;
      OutReady = 1'b1;
      collect(n_obs, n_exp, vo, ve);
      checks++;
      if (lost != 0 || n_obs != 2 || vo !== 128'b11 || ve !== 128'b11) begin
         errors++;
         $display("FAIL stall_resume: got n=%0d bits=%h want n=2 bits=3 (model %h) lost=%0d",
                  n_obs, vo, ve, lost);
      end
   endtask

   task automatic test_start_abort;
      int n_obs, n_exp;
      logic [127:0] vo, ve;
      lost = 0;
      do_start(2'b00);
      OutReady = 1'b0;
      send_bit(1'b1);
      OutReady = 1'b1;
      @(posedge Clock);
      #1;
      Rate    = 2'b00;
      Start   = 1'b1;
      InValid = 1'b1;
      InData  = 1'b1;
      @(negedge Clock);
      checks++;
      if (InReady !== 1'b0) begin
         errors++;
         $display("FAIL start_inready: got %b want 0", InReady);
      end
      @(posedge Clock);
      #1;
      Start   = 1'b0;
      InValid = 1'b0;
      InData  = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_drop: got %0d bits out want 1 bit of value 1", obs_q.size());
      end
      model_start(2'b00);
      send_bit(1'b0);
      collect(n_obs, n_exp, vo, ve);
      checks++;
      if (lost != 0 || n_obs != 2 || vo !== 128'b00 || ve !== 128'b00) begin
         errors++;
         $display("FAIL abort_sr_cleared: got n=%0d bits=%h want n=2 bits=0 (model %h)",
                  n_obs, vo, ve);
      end
   endtask

   task automatic test_rate11_and_reset;
      run_directed("rate11", 2'b11, 7, 14, 128'b11011111001011);
      do_start(2'b00);
      OutReady = 1'b0;
      send_bit(1'b1);
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1 || OutData !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b inready=%b data=%b want 0 1 0",
                  OutValid, InReady, OutData);
      end
      @(posedge Clock);
      #1;
      Reset    = 1'b0;
      OutReady = 1'b1;
      repeat (4) @(posedge Clock);
      #1;
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL reset_drops_frame: got %0d bits out want 0", obs_q.size());
      end
   endtask

   task automatic test_random;
      int n_obs, n_exp;
      logic [127:0] vo, ve;
      for (int round = 0; round < 4; round++) begin
         lost = 0;
         do_start(2'($urandom_range(0, 3)));
         fork
            begin
               for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
            end
            begin
               repeat (250) begin
                  @(posedge Clock);
                  #1;
                  OutReady = 1'($urandom_range(0, 1));
               end
               OutReady = 1'b1;
            end
         join
         collect(n_obs, n_exp, vo, ve);
         checks++;
         if (lost != 0 || n_obs != n_exp || vo !== ve) begin
            errors++;
            $display("FAIL random%0d_rate%0d: got n=%0d bits=%h want n=%0d bits=%h lost=%0d",
                     round, m_rate, n_obs, vo, n_exp, ve, lost);
         end
      end
   endtask

   initial begin
      model_start(2'b00);
      test_reset;
      test_rate_half;
      test_rate_34;
      test_rate_23;
      test_backpressure;
      test_start_abort;
      test_rate11_and_reset;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
